// File: rtl/quad_decoder_if.sv
// Encoder pins, control strobes and decoded outputs of quad_decoder.
// master drives pins/strobes and observes results; slave is the decoder.
interface quad_decoder_if #(
    parameter int WIDTH = 6
);
    logic             a_in;
    logic             b_in;
    logic             clr;
    logic             err_clr;
    logic             step;
    logic             down;
    logic [WIDTH-1:0] cnt;
    logic             err;

    modport master (
        output a_in, b_in, clr, err_clr,
        input  step, down, cnt, err
    );

    modport slave (
        input  a_in, b_in, clr, err_clr,
        output step, down, cnt, err
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder with synchroniser, glitch filter and wrapping position counter.
// Latency SYNC_STAGES+FILT_LEN edges from input level to step/cnt; no backpressure, pins free-run.
module quad_decoder #(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic           clk50m,
    input  logic           rst_n,
    quad_decoder_if.slave  bus
);
    localparam int RW = $clog2(FILT_LEN + 1);

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q, fill_q;
    logic [1:0]             s;
    logic                   s_vld;

    logic [1:0]    cand_q, cand_d;
    logic [RW-1:0] run_q, run_d;
    logic [1:0]    f_q, f_d;
    logic          f_vld_q, f_vld_d;

    logic [1:0]       state_q, state_d;
    logic             init_q, init_d;
    logic             step_q, step_d;
    logic             down_q, down_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    function automatic logic [1:0] up_next(input logic [1:0] st);
        case (st)
            S00:     return S10;
            S10:     return S11;
            S11:     return S01;
            default: return S00;
        endcase
    endfunction

    function automatic logic [1:0] dn_next(input logic [1:0] st);
        case (st)
            S00:     return S01;
            S01:     return S11;
            S11:     return S10;
            default: return S00;
        endcase
    endfunction

    // fill_q marks when the synchroniser holds real samples rather than reset zeros,
    // so the filter never accepts a level that was not actually seen on the pins.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
            fill_q   <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.a_in};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.b_in};
            fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign s     = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    assign s_vld = fill_q[SYNC_STAGES-1];

    always_comb begin
        cand_d  = cand_q;
        run_d   = run_q;
        f_d     = f_q;
        f_vld_d = f_vld_q;
        if (s_vld) begin
            if ((s != cand_q) || (run_q == '0)) begin
                cand_d = s;
                run_d  = RW'(1);
            end else if (run_q != RW'(FILT_LEN)) begin
                run_d = run_q + RW'(1);
            end
            if (run_d == RW'(FILT_LEN)) begin
                f_d     = s;
                f_vld_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        step_d  = 1'b0;
        down_d  = down_q;
        cnt_d   = cnt_q;
        err_d   = err_q & ~bus.err_clr;
        if (f_vld_q) begin
            if (init_q) begin
                state_d = f_q;
                init_d  = 1'b0;
            end else if (f_q != state_q) begin
                state_d = f_q;
                if (f_q == up_next(state_q)) begin
                    step_d = 1'b1;
                    down_d = 1'b0;
                    cnt_d  = cnt_q + WIDTH'(1);
                end else if (f_q == dn_next(state_q)) begin
                    step_d = 1'b1;
                    down_d = 1'b1;
                    cnt_d  = cnt_q - WIDTH'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        if (bus.clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= 2'b00;
            run_q   <= '0;
            f_q     <= 2'b00;
            f_vld_q <= 1'b0;
            state_q <= S00;
            init_q  <= 1'b1;
            step_q  <= 1'b0;
            down_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            run_q   <= run_d;
            f_q     <= f_d;
            f_vld_q <= f_vld_d;
            state_q <= state_d;
            init_q  <= init_d;
            step_q  <= step_d;
            down_q  <= down_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.step = step_q;
    assign bus.down = down_q;
    assign bus.cnt  = cnt_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: scenario tasks checked against a phase-index reference model.
module tb_quad_decoder;
    localparam int W   = 6;
    localparam int MOD = 1 << W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    quad_decoder_if #(.WIDTH(W)) bus ();

    quad_decoder #(.WIDTH(W), .SYNC_STAGES(2), .FILT_LEN(3)) u_dut (
        .clk50m (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: position of the accepted level within the 4-phase cycle.
    logic [1:0] m_lvl;
    int         m_cnt;
    logic       m_down;
    logic       m_err;

    function automatic int pos_of(input logic [1:0] l);
        case (l)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int model_apply(input logic [1:0] lvl);
        int d;
        d     = (pos_of(lvl) - pos_of(m_lvl) + 4) % 4;
        m_lvl = lvl;
        if (d == 1) begin
            m_cnt  = (m_cnt + 1) % MOD;
            m_down = 1'b0;
            return 1;
        end
        if (d == 3) begin
            m_cnt  = (m_cnt + MOD - 1) % MOD;
            m_down = 1'b1;
            return 1;
        end
        if (d == 2) m_err = 1'b1;
        return 0;
    endfunction

    // Drive a level at a falling edge; sample k is taken 1 time unit after edge N+k.
    task automatic move(input logic [1:0] lvl, input int hold, output int steps, output int first);
        steps = 0;
        first = -1;
        @(negedge clk);
        bus.a_in = lvl[1];
        bus.b_in = lvl[0];
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if (bus.step === 1'b1) begin
                steps++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic test_reset();
        int st, fi;
        rst_n = 1'b0; bus.a_in = 1'b0; bus.b_in = 1'b0; bus.clr = 1'b0; bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL reset_step: got %b want 0", bus.step); end
        total++; if (bus.down !== 1'b0) begin bad++; $display("FAIL reset_down: got %b want 0", bus.down); end
        total++; if (bus.cnt !== '0)    begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.cnt); end
        total++; if (bus.err !== 1'b0)  begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        m_lvl = 2'b00; m_cnt = 0; m_down = 1'b0; m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        move(2'b00, 20, st, fi);
        total++; if (st != 0) begin bad++; $display("FAIL idle_steps: got %0d want 0", st); end
        total++; if (bus.cnt !== W'(m_cnt)) begin bad++; $display("FAIL idle_cnt: got %0d want %0d", bus.cnt, m_cnt); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL idle_err: got %b want 0", bus.err); end
    endtask

    task automatic test_up();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        int st, fi, ex;
        for (int i = 0; i < 4; i++) begin
            ex = model_apply(seq[i]);
            move(seq[i], 10, st, fi);
            total++; if (st != ex) begin bad++; $display("FAIL up_steps[%0d]: got %0d want %0d", i, st, ex); end
            total++; if (fi != 5) begin bad++; $display("FAIL up_latency[%0d]: got %0d want 5", i, fi); end
            total++; if (bus.down !== m_down) begin bad++; $display("FAIL up_down[%0d]: got %b want %b", i, bus.down, m_down); end
        end
        total++; if (bus.cnt !== W'(4)) begin bad++; $display("FAIL up_cnt: got %0d want 4", bus.cnt); end
    endtask

    task automatic test_wrap();
        int st, fi, ex, sum;
        @(negedge clk); bus.clr = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.cnt !== '0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", bus.cnt); end
        @(negedge clk); bus.clr = 1'b0;
        m_cnt = 0;
        sum = 0;
        for (int i = 0; i < MOD; i++) begin
            ex = model_apply(2'(pos_of(m_lvl) == 0 ? 2'b10 : pos_of(m_lvl) == 1 ? 2'b11 : pos_of(m_lvl) == 2 ? 2'b01 : 2'b00));
            move(m_lvl, 6, st, fi);
            sum += st;
        end
        total++; if (sum != MOD) begin bad++; $display("FAIL wrap_steps: got %0d want %0d", sum, MOD); end
        total++; if (bus.cnt !== W'(m_cnt)) begin bad++; $display("FAIL wrap_cnt: got %0d want %0d", bus.cnt, m_cnt); end
        ex = model_apply(2'b01);
        move(2'b01, 8, st, fi);
        total++; if (bus.cnt !== W'(MOD - 1)) begin bad++; $display("FAIL wrap_dn_cnt: got %0d want %0d", bus.cnt, MOD - 1); end
        total++; if (bus.down !== 1'b1) begin bad++; $display("FAIL wrap_dn_down: got %b want 1", bus.down); end
        total++; if (st != ex) begin bad++; $display("FAIL wrap_dn_steps: got %0d want %0d", st, ex); end
    endtask

    task automatic test_glitch();
        int st, fi, ex;
        ex = model_apply(2'b00);
        move(2'b00, 8, st, fi);
        @(negedge clk); bus.a_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.a_in = 1'b0;
        move(2'b00, 15, st, fi);
        total++; if (st != 0) begin bad++; $display("FAIL glitch_steps: got %0d want 0", st); end
        total++; if (bus.cnt !== W'(m_cnt)) begin bad++; $display("FAIL glitch_cnt: got %0d want %0d", bus.cnt, m_cnt); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL glitch_err: got %b want 0", bus.err); end
    endtask

    task automatic test_illegal();
        int st, fi, ex;
        ex = model_apply(2'b11);
        move(2'b11, 10, st, fi);
        total++; if (st != ex) begin bad++; $display("FAIL ill_steps: got %0d want %0d", st, ex); end
        total++; if (bus.err !== m_err) begin bad++; $display("FAIL ill_err: got %b want %b", bus.err, m_err); end
        total++; if (bus.cnt !== W'(m_cnt)) begin bad++; $display("FAIL ill_cnt: got %0d want %0d", bus.cnt, m_cnt); end
        @(negedge clk); bus.err_clr = 1'b1;
        @(posedge clk); #1;
        m_err = 1'b0;
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL errclr: got %b want 0", bus.err); end
        @(negedge clk); bus.err_clr = 1'b0;
        ex = model_apply(2'b01);
        move(2'b01, 10, st, fi);
        total++; if (bus.cnt !== W'(m_cnt)) begin bad++; $display("FAIL ill_next_cnt: got %0d want %0d", bus.cnt, m_cnt); end
        total++; if (st != ex) begin bad++; $display("FAIL ill_next_steps: got %0d want %0d", st, ex); end
        ex = model_apply(2'b10);
        move(2'b10, 10, st, fi);
        total++; if (bus.err !== m_err) begin bad++; $display("FAIL ill2_err: got %b want %b", bus.err, m_err); end
        // Clear strobe lands on the very edge that decodes another illegal jump.
        ex = model_apply(2'b01);
        move(2'b01, 5, st, fi);
        @(negedge clk); bus.err_clr = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL setwins_err: got %b want 1", bus.err); end
        total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL setwins_step: got %b want 0", bus.step); end
        @(negedge clk); bus.err_clr = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    function automatic logic [1:0] up_of(input logic [1:0] l);
        logic [1:0] tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        return tbl[(pos_of(l) + 1) % 4];
    endfunction

    task automatic test_clr_step();
        int st, fi, ex;
        @(negedge clk); bus.clr = 1'b1;
        @(negedge clk); bus.clr = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            ex = model_apply(up_of(m_lvl));
            move(m_lvl, 6, st, fi);
        end
        total++; if (bus.cnt !== W'(10)) begin bad++; $display("FAIL pre_clr_cnt: got %0d want 10", bus.cnt); end
        ex = model_apply(up_of(m_lvl));
        move(m_lvl, 5, st, fi);
        @(negedge clk); bus.clr = 1'b1;
        @(posedge clk); #1;
        m_cnt = 0;
        total++; if (bus.step !== 1'b1) begin bad++; $display("FAIL clrstep_step: got %b want 1", bus.step); end
        total++; if (bus.cnt !== W'(m_cnt)) begin bad++; $display("FAIL clrstep_cnt: got %0d want %0d", bus.cnt, m_cnt); end
        total++; if (bus.down !== m_down) begin bad++; $display("FAIL clrstep_down: got %b want %b", bus.down, m_down); end
        @(negedge clk); bus.clr = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        int st, fi, ex, r;
        logic [1:0] tgt;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      tgt = up_of(up_of(m_lvl));
            else if (r == 1) tgt = m_lvl;
            else if (r < 6)  tgt = up_of(m_lvl);
            else             tgt = up_of(up_of(up_of(m_lvl)));
            ex = model_apply(tgt);
            move(tgt, $urandom_range(6, 12), st, fi);
            total++; if (st != ex) begin bad++; $display("FAIL rnd_steps[%0d]: got %0d want %0d", i, st, ex); end
            total++; if (bus.cnt !== W'(m_cnt)) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, bus.cnt, m_cnt); end
            total++; if (bus.down !== m_down) begin bad++; $display("FAIL rnd_down[%0d]: got %b want %b", i, bus.down, m_down); end
            total++; if (bus.err !== m_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, bus.err, m_err); end
        end
    endtask

    task automatic test_reset_mid();
        int st, fi, ex;
        @(negedge clk); bus.a_in = 1'b1; bus.b_in = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (bus.cnt !== '0)   begin bad++; $display("FAIL midrst_cnt: got %0d want 0", bus.cnt); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b want 0", bus.err); end
        total++; if (bus.down !== 1'b0) begin bad++; $display("FAIL midrst_down: got %b want 0", bus.down); end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        m_lvl = 2'b11; m_cnt = 0; m_down = 1'b0; m_err = 1'b0;
        move(2'b11, 20, st, fi);
        total++; if (st != 0) begin bad++; $display("FAIL midrst_steps: got %0d want 0", st); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL midrst_adopt_err: got %b want 0", bus.err); end
        ex = model_apply(2'b01);
        move(2'b01, 10, st, fi);
        total++; if (st != ex) begin bad++; $display("FAIL midrst_next_steps: got %0d want %0d", st, ex); end
        total++; if (bus.cnt !== W'(m_cnt)) begin bad++; $display("FAIL midrst_next_cnt: got %0d want %0d", bus.cnt, m_cnt); end
        total++; if (bus.down !== m_down) begin bad++; $display("FAIL midrst_next_down: got %b want %b", bus.down, m_down); end
    endtask

    initial begin
        test_reset();
        test_up();
        test_wrap();
        test_glitch();
        test_illegal();
        test_clr_step();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
